// File: rtl/sram_responder_if.sv
// MEM-stage data-memory request channel between the pipeline and the SRAM responder.
// Handshake: the MEM stage holds MEM_R_EN/MEM_W_EN, ALU_Res and VAL_RM while ready is 0; the access completes in the cycle ready is 1.
interface sram_responder_if;
    logic        MEM_R_EN;
    logic        MEM_W_EN;
    logic [31:0] ALU_Res;
    logic [31:0] VAL_RM;
    logic        ready;
    logic [31:0] DATA;

    modport master (output MEM_R_EN, MEM_W_EN, ALU_Res, VAL_RM, input ready, DATA);
    modport slave (input MEM_R_EN, MEM_W_EN, ALU_Res, VAL_RM, output ready, DATA);
endinterface

// File: rtl/sram_responder.sv
// Serves 32-bit MEM-stage word accesses from a 16-bit asynchronous SRAM as two half-word phases,
// holding ready low (pipeline frozen) until the word is complete.
module sram_responder #(
    parameter int BASE_ADDR   = 1024,
    parameter int SRAM_AW     = 18,
    parameter int WAIT_CYCLES = 2
) (
    input  logic               clk,
    input  logic               rst,
    sram_responder_if.slave    mem,
    output logic [SRAM_AW-1:0] SRAM_ADDR,
    inout  wire  [15:0]        SRAM_DQ,
    output logic               SRAM_WE_N,
    output logic               SRAM_OE_N,
    output logic               SRAM_CE_N,
    output logic               SRAM_UB_N,
    output logic               SRAM_LB_N,
    output logic [1:0]         dbg_state,
    output logic               dbg_dq_oe
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] LO   = 2'd1;
    localparam logic [1:0] HI   = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    logic [1:0]         state;
    logic [3:0]         cnt;
    logic               op_write;
    logic [31:0]        wdata;
    logic [SRAM_AW-2:0] wa_q;
    logic [31:0]        data_q;

    logic               req;
    logic               last;
    logic               dq_oe;
    logic [31:0]        offset;
    logic [SRAM_AW-2:0] wa;
    logic               unused_offset_bits;

    assign req    = mem.MEM_R_EN | mem.MEM_W_EN;
    // Byte offset to word index; the byte lane bits and out-of-range high bits are dropped.
    assign offset = mem.ALU_Res - 32'(BASE_ADDR);
    assign wa     = offset[SRAM_AW:2];
    assign unused_offset_bits = ^{offset[31:SRAM_AW+1], offset[1:0]};

    assign last      = (cnt == 4'(WAIT_CYCLES - 1));
    assign mem.ready = ~req | (state == DONE);
    assign mem.DATA  = data_q;

    assign dq_oe     = op_write & ((state == LO) | (state == HI));
    assign SRAM_DQ   = dq_oe ? ((state == HI) ? wdata[31:16] : wdata[15:0]) : 16'hzzzz;
    assign SRAM_OE_N = 1'b0;
    assign SRAM_CE_N = 1'b0;
    assign SRAM_UB_N = 1'b0;
    assign SRAM_LB_N = 1'b0;
    assign dbg_state = state;
    assign dbg_dq_oe = dq_oe;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            op_write  <= 1'b0;
            wdata     <= 32'd0;
            wa_q      <= '0;
            data_q    <= 32'd0;
            SRAM_ADDR <= '0;
            SRAM_WE_N <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (req) begin
                        state     <= LO;
                        cnt       <= 4'd0;
                        op_write  <= mem.MEM_W_EN;
                        wdata     <= mem.VAL_RM;
                        wa_q      <= wa;
                        SRAM_ADDR <= {wa, 1'b0};
                        SRAM_WE_N <= ~mem.MEM_W_EN;
                    end
                end
                LO: begin
                    if (last) begin
                        // WE_N stays low across the phase change; only the address moves.
                        cnt       <= 4'd0;
                        state     <= HI;
                        SRAM_ADDR <= {wa_q, 1'b1};
                        if (!op_write) data_q[15:0] <= SRAM_DQ;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                HI: begin
                    if (last) begin
                        cnt       <= 4'd0;
                        state     <= DONE;
                        SRAM_WE_N <= 1'b1;
                        if (!op_write) data_q[31:16] <= SRAM_DQ;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sram_responder.sv
// Bench for sram_responder: directed literal checks plus randomized traffic compared each cycle
// against a transaction-level model that tracks cycles elapsed since the request was accepted.
module tb_sram_responder;
    localparam int W0     = 2;
    localparam int DONE_K = 2 * W0 + 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    logic chk_en = 1'b0;

    sram_responder_if m0();
    sram_responder_if m1();

    logic [17:0] a0, a1;
    wire  [15:0] dq0, dq1;
    logic        we0, we1;
    logic [3:0]  t0, t1;
    logic [1:0]  st0, st1;
    logic        oe0, oe1;

    sram_responder #(.BASE_ADDR(1024), .SRAM_AW(18), .WAIT_CYCLES(W0)) u0 (
        .clk(clk), .rst(rst), .mem(m0),
        .SRAM_ADDR(a0), .SRAM_DQ(dq0), .SRAM_WE_N(we0),
        .SRAM_OE_N(t0[0]), .SRAM_CE_N(t0[1]), .SRAM_UB_N(t0[2]), .SRAM_LB_N(t0[3]),
        .dbg_state(st0), .dbg_dq_oe(oe0)
    );

    sram_responder #(.BASE_ADDR(1024), .SRAM_AW(18), .WAIT_CYCLES(1)) u1 (
        .clk(clk), .rst(rst), .mem(m1),
        .SRAM_ADDR(a1), .SRAM_DQ(dq1), .SRAM_WE_N(we1),
        .SRAM_OE_N(t1[0]), .SRAM_CE_N(t1[1]), .SRAM_UB_N(t1[2]), .SRAM_LB_N(t1[3]),
        .dbg_state(st1), .dbg_dq_oe(oe1)
    );

    // SRAM models
    logic [15:0] sram0     [0:511];
    logic [15:0] sram1     [0:511];
    logic [15:0] ref_mem   [0:511];
    logic [15:0] init_copy [0:511];
    logic        load_en = 1'b0;
    logic [8:0]  load_a  = 9'd0;
    logic [15:0] load_d  = 16'd0;

    // Reference model: k counts cycles since acceptance (0 = idle, 1..W0 low, W0+1..2*W0 high, DONE_K done)
    int          k        = 0;
    logic        m_wr     = 1'b0;
    logic [16:0] m_wa     = 17'd0;
    logic [31:0] m_wd     = 32'd0;
    logic [31:0] exp_data = 32'd0;
    logic        rd_phase0;

    assign rd_phase0 = we0 && (k >= 1) && (k <= 2 * W0) && !m_wr;
    assign dq0 = rd_phase0 ? sram0[a0[8:0]] : 16'hzzzz;
    assign dq1 = we1 ? sram1[a1[8:0]] : 16'hzzzz;

    always @(posedge clk) begin
        if (load_en) begin
            sram0[load_a] <= load_d;
            sram1[load_a] <= load_d;
        end else if (!we0) begin
            sram0[a0[8:0]] <= dq0;
        end
    end

    always @(posedge clk) begin
        if (load_en) ref_mem[load_a] <= load_d;
        else if (k >= 1 && k <= 2 * W0 && m_wr) begin
            if (k <= W0) ref_mem[{m_wa[7:0], 1'b0}] <= m_wd[15:0];
            else         ref_mem[{m_wa[7:0], 1'b1}] <= m_wd[31:16];
        end
        if (rst) begin
            k        <= 0;
            exp_data <= 32'd0;
        end else if (k == 0) begin
            if (m0.MEM_R_EN | m0.MEM_W_EN) begin
                k    <= 1;
                m_wr <= m0.MEM_W_EN;
                m_wa <= 17'((m0.ALU_Res - 32'd1024) >> 2);
                m_wd <= m0.VAL_RM;
            end
        end else if (k == DONE_K) begin
            k <= 0;
        end else begin
            k <= k + 1;
            if (!m_wr && k == W0)     exp_data[15:0]  <= ref_mem[{m_wa[7:0], 1'b0}];
            if (!m_wr && k == 2 * W0) exp_data[31:16] <= ref_mem[{m_wa[7:0], 1'b1}];
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        #2;
        if (chk_en) begin
            check("ready", 32'(m0.ready), 32'(!(m0.MEM_R_EN | m0.MEM_W_EN) || k == DONE_K));
            check("data", m0.DATA, exp_data);
            if (k >= 1 && k <= 2 * W0) begin
                check("addr", 32'(a0), 32'({m_wa, 1'(k > W0)}));
                check("we_n", 32'(we0), 32'(!m_wr));
                check("dq_oe", 32'(oe0), 32'(m_wr));
                if (m_wr) check("dq", 32'(dq0), 32'((k <= W0) ? m_wd[15:0] : m_wd[31:16]));
            end else begin
                check("we_n_idle", 32'(we0), 32'd1);
                check("dq_oe_idle", 32'(oe0), 32'd0);
            end
        end
    end

    // Drivers
    task automatic run0(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d,
                        output int lat, output int welo);
        @(negedge clk);
        m0.MEM_R_EN = r; m0.MEM_W_EN = w; m0.ALU_Res = a; m0.VAL_RM = d;
        lat = -1; welo = 0;
        for (int c = 0; c < 40; c++) begin
            #2;
            if (!we0) welo++;
            if (m0.ready) begin
                lat = c;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic idle0();
        @(negedge clk);
        m0.MEM_R_EN = 1'b0; m0.MEM_W_EN = 1'b0;
    endtask

    task automatic run1(input logic [31:0] a, output int lat, output logic [17:0] ad1, output logic [17:0] ad2);
        @(negedge clk);
        m1.MEM_R_EN = 1'b1; m1.MEM_W_EN = 1'b0; m1.ALU_Res = a; m1.VAL_RM = 32'd0;
        lat = -1; ad1 = '0; ad2 = '0;
        for (int c = 0; c < 40; c++) begin
            #2;
            if (c == 1) ad1 = a1;
            if (c == 2) ad2 = a1;
            if (m1.ready) begin
                lat = c;
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
        m1.MEM_R_EN = 1'b0;
    endtask

    initial begin
        int lat, lat2, welo;
        logic [17:0] ad1, ad2;
        m0.MEM_R_EN = 1'b0; m0.MEM_W_EN = 1'b0; m0.ALU_Res = 32'd0; m0.VAL_RM = 32'd0;
        m1.MEM_R_EN = 1'b0; m1.MEM_W_EN = 1'b0; m1.ALU_Res = 32'd0; m1.VAL_RM = 32'd0;

        // Reset while preloading both SRAMs and the reference image
        load_en = 1'b1;
        for (int i = 0; i < 512; i++) begin
            load_a = 9'(i);
            load_d = 16'($urandom);
            init_copy[i] = load_d;
            @(negedge clk);
        end
        load_en = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        chk_en = 1'b1;
        #3;
        check("rst_ready", 32'(m0.ready), 32'd1);
        check("rst_data", m0.DATA, 32'd0);
        check("rst_addr", 32'(a0), 32'd0);
        check("rst_we_n", 32'(we0), 32'd1);
        check("rst_dq_oe", 32'(oe0), 32'd0);
        check("ties0", 32'(t0), 32'd0);
        check("ties1", 32'(t1), 32'd0);

        // Write 0xDEADBEEF to 1024
        run0(1'b0, 1'b1, 32'd1024, 32'hDEADBEEF, lat, welo);
        check("wr_latency", lat, 32'd5);
        check("wr_we_low_cycles", welo, 32'd4);
        idle0();
        check("sram_w0", 32'(sram0[0]), 32'h0000BEEF);
        check("sram_w1", 32'(sram0[1]), 32'h0000DEAD);

        // Read it back; then a write must leave DATA alone
        run0(1'b1, 1'b0, 32'd1024, 32'd0, lat, welo);
        check("rd_latency", lat, 32'd5);
        check("rd_data", m0.DATA, 32'hDEADBEEF);
        idle0();
        run0(1'b0, 1'b1, 32'd1028, 32'h12345678, lat, welo);
        idle0();
        check("data_after_wr", m0.DATA, 32'hDEADBEEF);
        check("sram_w2", 32'(sram0[2]), 32'h00005678);
        check("sram_w3", 32'(sram0[3]), 32'h00001234);

        // Back-to-back write then read of 1032
        run0(1'b0, 1'b1, 32'd1032, 32'h0000AAAA, lat, welo);
        run0(1'b1, 1'b0, 32'd1032, 32'd0, lat2, welo);
        check("b2b_cycles", lat + 1 + lat2, 32'd11);
        check("b2b_data", m0.DATA, 32'h0000AAAA);
        idle0();

        // Both enables high acts as a write
        run0(1'b1, 1'b1, 32'd1036, 32'h00000055, lat, welo);
        idle0();
        check("both_latency", lat, 32'd5);
        check("both_data_kept", m0.DATA, 32'h0000AAAA);
        check("sram_w6", 32'(sram0[6]), 32'h00000055);
        check("sram_w7", 32'(sram0[7]), 32'h00000000);

        // Reset during the second high-phase cycle of a write
        @(negedge clk);
        m0.MEM_W_EN = 1'b1; m0.ALU_Res = 32'd1040; m0.VAL_RM = 32'hCAFEF00D;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        m0.MEM_W_EN = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #3;
        check("abort_we_n", 32'(we0), 32'd1);
        check("abort_dq_oe", 32'(oe0), 32'd0);
        check("abort_ready", 32'(m0.ready), 32'd1);
        check("abort_data", m0.DATA, 32'd0);
        check("sram_w8", 32'(sram0[8]), 32'h0000F00D);
        run0(1'b1, 1'b0, 32'd1040, 32'd0, lat, welo);
        check("post_abort_latency", lat, 32'd5);
        idle0();

        // Single-wait-cycle instance
        run1(32'd1424, lat, ad1, ad2);
        check("w1_latency", lat, 32'd3);
        check("w1_addr_lo", 32'(ad1), 32'd200);
        check("w1_addr_hi", 32'(ad2), 32'd201);
        check("w1_data", m1.DATA, {init_copy[201], init_copy[200]});
        run1(32'd1025, lat, ad1, ad2);
        check("w1_unaligned_addr", 32'(ad1), 32'd0);
        check("w1_unaligned_data", m1.DATA, {init_copy[1], init_copy[0]});

        // Randomized traffic, checked cycle by cycle against the model
        for (int n = 0; n < 2000; n++) begin
            @(negedge clk);
            rst = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 3) == 0) begin
                m0.MEM_R_EN = 1'($urandom_range(0, 1));
                m0.MEM_W_EN = 1'($urandom_range(0, 1));
                m0.ALU_Res  = 32'd1024 + 32'(4 * $urandom_range(0, 255)) + 32'($urandom_range(0, 3));
                m0.VAL_RM   = $urandom;
            end
        end
        @(negedge clk);
        rst = 1'b0;
        m0.MEM_R_EN = 1'b0; m0.MEM_W_EN = 1'b0;
        repeat (12) @(negedge clk);
        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
